// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode constants, FSM state type and a parity helper.
// Used by the buffered transmitter and, later, by its receiver counterpart.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Even parity is the plain XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input int mode, input logic data_xor);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Valid/ready word stream feeding the buffered UART transmitter.
interface uart_tx_buffered_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
// DEPTH must be a power of two; push when full and pop when empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;

    assign used  = wr_ptr - rd_ptr;
    assign full  = used[AW];
    assign empty = (used == '0);
    assign count = CW'(used);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately left unreset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: configurable frame format, runtime baud divisor, back-to-back frames.
// Optional hardware flow control (cts_n input) is enabled by defining UART_TX_CTS_EN.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
`ifdef UART_TX_CTS_EN
    input  logic                              cts_n,
`endif
    uart_tx_buffered_if.slave                 src,
    input  logic [DIV_W-1:0]                  baud_div,
    output logic                              tx,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_e       state;
    logic [DIV_W-1:0]  period;
    logic [DIV_W-1:0]  cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] head;
    logic [3:0]        bit_cnt;
    logic              par;
    logic              full, empty, push, pop;
    logic              cts_ok, can_start, bit_done, last_stop;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    // Synchroniser resets to "not clear", so nothing starts until CTS is seen low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cts_sync <= 2'b11;
        else          cts_sync <= {cts_sync[0], cts_n};
    end
    assign cts_ok = ~cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    assign push         = src.in_valid && !full;
    assign src.in_ready = !full;
    assign bit_done     = (cnt == '0);
    assign last_stop    = (state == ST_STOP) && bit_done && (bit_cnt == LAST_STOP);
    assign can_start    = !empty && cts_ok;
    assign pop          = can_start && ((state == ST_IDLE) || last_stop);

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (src.in_data),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // A pop always starts a frame, whether from IDLE or straight out of the last stop bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            period  <= '0;
            cnt     <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else if (pop) begin
            state   <= ST_START;
            shift   <= head;
            par     <= parity_bit(PARITY, ^head);
            period  <= baud_div;
            cnt     <= baud_div;
            bit_cnt <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
                ST_START: begin
                    if (bit_done) begin
                        state <= ST_DATA;
                        cnt   <= period;
                        tx    <= shift[0];
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        cnt <= period;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        state <= ST_STOP;
                        cnt   <= period;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= ST_IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            cnt     <= period;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: two instances (even/1-stop and odd/2-stop, 4-deep FIFO) against a frame-level model.
// Flow-control stimulus is added when UART_TX_CTS_EN is defined.
module tb_uart_tx_buffered;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cts_n = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic        cmp_en = 1'b0;

    logic       tx_a, busy_a, tx_b, busy_b;
    logic [2:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_buffered_if #(.DATA_W(8)) bus_a ();
    uart_tx_buffered_if #(.DATA_W(8)) bus_b ();

    uart_tx_buffered #(
        .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .DIV_W(16)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef UART_TX_CTS_EN
        .cts_n      (cts_n),
`endif
        .src        (bus_a),
        .baud_div   (baud_div),
        .tx         (tx_a),
        .tx_busy    (busy_a),
        .fifo_count (cnt_a)
    );

    uart_tx_buffered #(
        .DATA_W(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .DIV_W(16)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef UART_TX_CTS_EN
        .cts_n      (cts_n),
`endif
        .src        (bus_b),
        .baud_div   (baud_div),
        .tx         (tx_b),
        .tx_busy    (busy_b),
        .fifo_count (cnt_b)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // ---------------- frame-level model ----------------
    function automatic int par_mode(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int frame_bits(input int i);
        return 1 + 8 + 1 + ((i == 0) ? 1 : 2);
    endfunction

    // Bit k of a frame: start, 8 data bits LSB first, parity, then stop bits.
    function automatic logic exp_bit(input int i, input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
        if (k == 9) return (par_mode(i) == 1) ? ^w : ~(^w);
        return 1'b1;
    endfunction

    logic [7:0] m_q [2][DEPTH];
    int         m_head [2];
    int         m_cnt [2];
    bit         m_busy [2];
    logic [7:0] m_word [2];
    int         m_per [2];
    int         m_cyc [2];
    bit         m_s0 = 1'b1;
    bit         m_s1 = 1'b1;

    // NOTE: the model is behavioural bench code, so blocking updates in program order are intended.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_head[i] = 0;
                m_cnt[i]  = 0;
                m_busy[i] = 1'b0;
                m_cyc[i]  = 0;
            end
            m_s0 = 1'b1;
            m_s1 = 1'b1;
        end else begin
            bit ok;
`ifdef UART_TX_CTS_EN
            ok   = !m_s1;
            m_s1 = m_s0;
            m_s0 = cts_n;
`else
            ok = 1'b1;
`endif
            for (int i = 0; i < 2; i++) begin
                bit         v;
                logic [7:0] d;
                bit         accept;
                v      = (i == 0) ? bus_a.in_valid : bus_b.in_valid;
                d      = (i == 0) ? bus_a.in_data : bus_b.in_data;
                accept = v && (m_cnt[i] < DEPTH);
                if (m_busy[i]) begin
                    if (m_cyc[i] + 1 == frame_bits(i) * (m_per[i] + 1)) m_busy[i] = 1'b0;
                    else m_cyc[i]++;
                end
                if (!m_busy[i] && m_cnt[i] > 0 && ok) begin
                    m_word[i] = m_q[i][m_head[i]];
                    m_head[i] = (m_head[i] + 1) % DEPTH;
                    m_cnt[i]--;
                    m_busy[i] = 1'b1;
                    m_cyc[i]  = 0;
                    m_per[i]  = int'(baud_div);
                end
                if (accept) begin
                    m_q[i][(m_head[i] + m_cnt[i]) % DEPTH] = d;
                    m_cnt[i]++;
                end
            end
        end
    end

    task automatic cmp(input int i, input logic t, input logic b, input logic [2:0] c, input logic r);
        string tag;
        logic  et;
        tag = (i == 0) ? "a" : "b";
        et  = m_busy[i] ? exp_bit(i, m_word[i], m_cyc[i] / (m_per[i] + 1)) : 1'b1;
        check($sformatf("%s.tx", tag), t, et);
        check($sformatf("%s.tx_busy", tag), b, m_busy[i]);
        check($sformatf("%s.fifo_count", tag), c, m_cnt[i]);
        check($sformatf("%s.in_ready", tag), r, m_cnt[i] < DEPTH);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, tx_a, busy_a, cnt_a, bus_a.in_ready);
            cmp(1, tx_b, busy_b, cnt_b, bus_b.in_ready);
        end
    end

    // Length of the most recent uninterrupted tx_busy run, in cycles.
    int run_a = 0, last_a = 0, run_b = 0, last_b = 0;
    always @(negedge clk) begin
        if (busy_a) run_a++;
        else if (run_a != 0) begin last_a = run_a; run_a = 0; end
        if (busy_b) run_b++;
        else if (run_b != 0) begin last_b = run_b; run_b = 0; end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input int i, input logic v, input logic [7:0] d);
        if (i == 0) begin bus_a.in_valid = v; bus_a.in_data = d; end
        else        begin bus_b.in_valid = v; bus_b.in_data = d; end
    endtask

    function automatic logic ready_of(input int i);
        return (i == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction

    // Called just after a falling edge; returns on the falling edge after acceptance.
    task automatic push(input int i, input logic [7:0] d);
        int guard;
        guard = 0;
        set_in(i, 1'b1, d);
        while (!ready_of(i) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) timeout("push");
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        set_in(i, 1'b0, 8'h00);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (((i == 0) ? (busy_a || cnt_a != 0) : (busy_b || cnt_b != 0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) timeout("wait_idle");
        tick(2);
    endtask

    int   seq_a [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    int   seq_b [12] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
    logic log_a [60], log_b [60], bz_a [60], bz_b [60];

    initial begin
        int first_a, first_b, nb_a, nb_b, lows, lat;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);

        // Reset state
        reset_n = 1'b0;
        tick(1);
        cmp_en = 1'b1;
        tick(2);
        check("rst.tx", tx_a, 1'b1);
        check("rst.tx_busy", busy_a, 1'b0);
        check("rst.fifo_count", cnt_a, 3'd0);
        check("rst.in_ready", bus_a.in_ready, 1'b1);
        reset_n = 1'b1;
        tick(3);

        // 0xA5 into both instances: even/1-stop (44 cycles) and odd/2-stop (48 cycles), baud_div=3
        baud_div = 16'd3;
        set_in(0, 1'b1, 8'hA5);
        set_in(1, 1'b1, 8'hA5);
        @(posedge clk);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            log_a[c] = tx_a; bz_a[c] = busy_a;
            log_b[c] = tx_b; bz_b[c] = busy_b;
            if (c == 0) begin
                set_in(0, 1'b0, 8'h00);
                set_in(1, 1'b0, 8'h00);
            end
        end
        first_a = -1; first_b = -1; nb_a = 0; nb_b = 0;
        for (int c = 59; c >= 0; c--) begin
            if (bz_a[c]) begin first_a = c; nb_a++; end
            if (bz_b[c]) begin first_b = c; nb_b++; end
        end
        check("a.start_latency", first_a, 1);
        check("a.busy_cycles", nb_a, 44);
        check("b.busy_cycles", nb_b, 48);
        for (int k = 0; k < 11; k++) check($sformatf("a.bit%0d", k), log_a[2 + 4*k], seq_a[k]);
        for (int k = 0; k < 12; k++) check($sformatf("b.bit%0d", k), log_b[2 + 4*k], seq_b[k]);
        tick(4);

        // Fill the 4-deep FIFO while busy; six frames back to back
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        push(0, 8'h04);
        push(0, 8'h05);
        check("fill.fifo_count", cnt_a, 3'd4);
        check("fill.in_ready", bus_a.in_ready, 1'b0);
        push(0, 8'h06);
        wait_idle(0, 600);
        check("fill.busy_run", last_a, 264);
        check("fill.fifo_count_end", cnt_a, 3'd0);

        // Reset ten cycles into a frame with a second word queued
        push(0, 8'hA5);
        push(0, 8'h77);
        tick(9);
        check("abort.tx_before", tx_a, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("abort.tx", tx_a, 1'b1);
        check("abort.tx_busy", busy_a, 1'b0);
        check("abort.fifo_count", cnt_a, 3'd0);
        tick(2);
        reset_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        check("abort.no_residual", lows, 0);
        push(0, 8'h3C);
        wait_idle(0, 200);
        check("abort.new_frame_run", last_a, 44);

        // Divisor change mid-frame only affects the next frame
        push(0, 8'h11);
        push(0, 8'h22);
        tick(8);
        baud_div = 16'd7;
        wait_idle(0, 400);
        check("baud.busy_run", last_a, 44 + 88);

        // Divisor 0: one-cycle bits
        baud_div = 16'd0;
        push(0, 8'hFF);
        wait_idle(0, 100);
        check("baud0.busy_run", last_a, 11);
        baud_div = 16'd3;

`ifdef UART_TX_CTS_EN
        // Flow control: hold off, then release, then deassert mid-frame
        cts_n = 1'b1;
        tick(4);
        push(0, 8'h55);
        tick(20);
        check("cts.held_busy", busy_a, 1'b0);
        check("cts.held_tx", tx_a, 1'b1);
        check("cts.held_count", cnt_a, 3'd1);
        cts_n = 1'b0;
        lat = 0;
        while (tx_a !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("cts.start_latency", lat, 3);
        tick(8);
        cts_n = 1'b1;
        wait_idle(0, 200);
        check("cts.no_truncate_run", last_a, 44);
        cts_n = 1'b0;
        tick(4);
`endif

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Parametrised UART transmitter, next generation of the team's fixed-format TX.
- Frame format is compile-time configurable: data width, parity mode and stop-bit count.
- Baud divisor is set at runtime.
- An internal FIFO accepts words over a valid/ready handshake and sends frames back-to-back.
- Sits between a CPU/DMA byte stream and the board TX pin.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9, sent LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 16, TX FIFO entries; power of 2, at least 2.
DIV_W, 16, width of baud_div.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
in_data  in  DATA_W  word to transmit.
in_valid  in  1  in_data valid.
in_ready  out  1  FIFO can accept a word; high iff FIFO not full.
baud_div  in  DIV_W  bit period = baud_div+1 clk cycles.
tx  out  1  serial line; idles high.
tx_busy  out  1  high while a frame is in flight.
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of words queued (excludes the word being shifted).
cts_n  in  1  clear-to-send, active low; present only with UART_TX_CTS_EN.

Behaviour:
- Reset (reset_n low, async): tx=1, tx_busy=0, in_ready=1, fifo_count=0, FIFO pointers cleared. FSM goes to IDLE; bit counter and shift register are zeroed. Reset mid-frame aborts the frame immediately; tx returns high with no glitch low.
- Write handshake: a word is accepted on a rising edge where in_valid && in_ready. in_ready depends only on the full flag; a pop in the same cycle does not free space, so there is no full-FIFO passthrough.
- Simultaneous push and pop on a non-full, non-empty FIFO: fifo_count unchanged.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE, or STOP -> START.
- IDLE: if FIFO is non-empty (and CTS permits), pop the head into the shift register and latch baud_div into a period register. Go to START; tx_busy rises in the same edge.
- Each state holds for exactly baud_div+1 cycles, counted by a DIV_W-bit down-counter reloaded from the latched period. Changing baud_div mid-frame has no effect until the next frame.
- baud_div=0 is legal and gives 1-cycle bits.
- START: tx=0. DATA: tx = shift[0]; shift right once per bit, DATA_W bits.
- PARITY: even outputs the XOR of all DATA_W bits; odd outputs its inverse.
- STOP: tx=1 for STOP_BITS bit periods. At the end of the last stop bit:
  - FIFO non-empty (and CTS permits): go directly to START, with no idle gap, and tx_busy stays high.
  - Otherwise: go to IDLE, with tx_busy=0.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1; tx goes low after edge N+1.
- Frame length: (1 + DATA_W + (PARITY!=0) + STOP_BITS) * (baud_div+1) cycles.
- tx is registered, with no combinational path from any input to tx.

Optional Feature:
UART_TX_CTS_EN
- Defined: the cts_n port exists and is synchronised through 2 flops. A frame starts (IDLE or STOP exit) only when the synchronised cts_n is low; otherwise the FSM waits in IDLE with tx_busy=0.
- Deasserting cts_n mid-frame never aborts the current frame.
- Undefined: no cts_n port, and frames start unconditionally.

Decomposition:
- Shared package uart_pkg holds:
  - the parity-mode constants PARITY_NONE, PARITY_EVEN, PARITY_ODD;
  - the FSM state typedef.
- uart_rx's successor will reuse the same package.
- One sub-module, uart_sync_fifo: a synchronous FIFO (parametrised width and depth) with push, pop, full, empty and count outputs, instantiated once.
- FSM and shifter stay in the top module.

Test Plan:
1. DATA_W=8, PARITY=1, STOP_BITS=1, baud_div=3, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles (44 cycles total); parity bit 0; tx_busy high for exactly 44 cycles.
2. PARITY=2, STOP_BITS=2, push 0xA5 -> parity bit 1, stop high for 8 cycles, frame length 48 cycles.
3. FIFO_DEPTH=4, hold in_valid with 0x01..0x06 while the FSM is busy -> in_ready drops once 4 words are queued. All 6 words are sent in order with no idle gap between frames, and fifo_count returns to 0.
4. Assert reset_n low at cycle 10 of a frame -> tx=1 immediately, tx_busy=0, fifo_count=0. After release no residual frame is sent, and a new push of 0x3C transmits correctly.
5. Change baud_div from 3 to 7 mid-frame -> the current frame keeps 4-cycle bits; the next queued frame uses 8-cycle bits.
6. With UART_TX_CTS_EN, cts_n=1 and 0x55 pushed -> tx stays high and tx_busy=0. Drive cts_n=0 -> the frame starts within 3 cycles; raising cts_n mid-frame does not truncate it.
